pwu_req_arbiter: RTL and testbench

Shares one page-walker instance between NUM_REQ translation requesters. It picks one requester per cycle with round-robin arbitration and forwards its virtual address to the walker input handshake. It records the owner of every accepted request in an in-order tag FIFO and routes each walker result (PA, fault) back to that owner. It sits between the requester ports of the PWU and the walker.

---
 rtl/pwu_pkg.sv | 11 +
 rtl/pwu_tag_fifo.sv | 42 ++++
 rtl/pwu_req_arbiter.sv | 138 +++++++++++++
 tb/tb_pwu_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwu_pkg.sv
// Shared types and widths for the page-walker unit.
// Requester ids are sized for the largest supported requester count.
package pwu_pkg;
  localparam int VA_W        = 32;
  localparam int PA_W        = 28;
  localparam int FAULT_CNT_W = 16;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;
endpackage

// File: rtl/pwu_tag_fifo.sv
// In-order owner-tag FIFO for outstanding walker requests.
// Pointers carry a wrap bit so full/empty fall out of one compare.
module pwu_tag_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q <= wr_q + ONE;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + ONE;
    end
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/pwu_req_arbiter.sv
// Round-robin sharing of one page walker between requesters.
// Owner tags are queued in order and steer walker results back.
module pwu_req_arbiter
  import pwu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*32-1:0]         req_va_i,
  input  logic [NUM_REQ-1:0]            req_vld_i,
  output logic [NUM_REQ-1:0]            req_rdy_o,
  output logic [27:0]                   rsp_pa_o,
  output logic [NUM_REQ-1:0]            rsp_vld_o,
  output logic [NUM_REQ-1:0]            rsp_fault_o,
  output logic [31:0]                   wk_va_o,
  output logic                          wk_va_vld_o,
  input  logic                          wk_va_rdy_i,
  input  logic [27:0]                   wk_pa_i,
  input  logic                          wk_pa_vld_i,
  input  logic                          wk_pa_fault_i,
  output logic [$clog2(TAG_DEPTH):0]    outstanding_o,
  output logic [15:0]                   fault_cnt_o,
  output logic                          err_o
);
  function automatic req_id_t rr_pick(input logic [MAX_REQ-1:0] v,
                                      input req_id_t ptr);
    int idx;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (v[idx]) rr_pick = req_id_t'(idx);
    end
  endfunction

  logic                   lock_q, lock_d;
  req_id_t                lock_id_q, lock_id_d;
  req_id_t                rr_q, rr_d;
  logic                   err_q, err_d;
  logic [PA_W-1:0]        pa_q, pa_d;
  logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;

  logic [MAX_REQ-1:0] vld_ext, rdy_ext, rsp_ext, flt_ext;
  logic               lock_hold, any_vld, va_vld, accept, pop;
  logic               full, empty;
  req_id_t            grant, head;

  assign vld_ext   = MAX_REQ'(req_vld_i);
  assign any_vld   = |req_vld_i;
  assign lock_hold = lock_q & vld_ext[lock_id_q];
  // A dropped lock falls back to the round-robin pick this cycle.
  assign grant     = lock_hold ? lock_id_q : rr_pick(vld_ext, rr_q);
  assign va_vld    = any_vld & ~full;
  assign accept    = va_vld & wk_va_rdy_i;
  assign pop       = wk_pa_vld_i & ~empty;

  pwu_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .wdata_i (grant),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  always_comb begin
    rdy_ext = '0;
    rsp_ext = '0;
    flt_ext = '0;
    if (accept) rdy_ext[grant] = 1'b1;
    if (pop) begin
      rsp_ext[head] = 1'b1;
      flt_ext[head] = wk_pa_fault_i;
    end
  end

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q;
    pa_d      = pa_q;
    fcnt_d    = fcnt_q;
    if (lock_q && !lock_hold) begin
      lock_d = 1'b0;
      err_d  = 1'b1;
    end
    if (va_vld && !wk_va_rdy_i) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    if (accept) begin
      lock_d = 1'b0;
      rr_d   = req_id_t'((int'(grant) + 1) % NUM_REQ);
    end
    if (wk_pa_vld_i) begin
      pa_d = wk_pa_i;
      if (empty) err_d = 1'b1;
    end
    if (pop && wk_pa_fault_i && fcnt_q != '1)
      fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      pa_q      <= '0;
      fcnt_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      pa_q      <= pa_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign req_rdy_o   = rst_i ? '0 : rdy_ext[NUM_REQ-1:0];
  assign rsp_vld_o   = rst_i ? '0 : rsp_ext[NUM_REQ-1:0];
  assign rsp_fault_o = rst_i ? '0 : flt_ext[NUM_REQ-1:0];
  assign wk_va_vld_o = ~rst_i & va_vld;
  assign wk_va_o     = (rst_i || !any_vld) ? '0 :
                       req_va_i[VA_W*int'(grant) +: VA_W];
  assign rsp_pa_o    = rst_i ? '0 : (pop ? wk_pa_i : pa_q);
  assign fault_cnt_o = fcnt_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_pwu_req_arbiter.sv
// Bench for pwu_req_arbiter: directed table, corner sequences,
// and protocol-respecting random traffic against a queue model.
module tb_pwu_req_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] req_va;
  logic [N-1:0]    req_vld, req_rdy;
  logic [27:0]     rsp_pa;
  logic [N-1:0]    rsp_vld, rsp_fault;
  logic [31:0]     wk_va;
  logic            wk_va_vld, wk_rdy;
  logic [27:0]     wk_pa;
  logic            wk_pa_vld, wk_fault;
  logic [2:0]      outst;
  logic [15:0]     fcnt;
  logic            err;

  int vec_n  = 0;
  int miss_n = 0;

  always #5 clk = ~clk;

  pwu_req_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_va_i      (req_va),
    .req_vld_i     (req_vld),
    .req_rdy_o     (req_rdy),
    .rsp_pa_o      (rsp_pa),
    .rsp_vld_o     (rsp_vld),
    .rsp_fault_o   (rsp_fault),
    .wk_va_o       (wk_va),
    .wk_va_vld_o   (wk_va_vld),
    .wk_va_rdy_i   (wk_rdy),
    .wk_pa_i       (wk_pa),
    .wk_pa_vld_i   (wk_pa_vld),
    .wk_pa_fault_i (wk_fault),
    .outstanding_o (outst),
    .fault_cnt_o   (fcnt),
    .err_o         (err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: owner queue, rotating pointer, held grant.
  int          m_rr, m_lid, m_fc, m_acc;
  bit          m_lock, m_err;
  int          m_q[$];
  logic [27:0] m_pa;

  function automatic void m_reset();
    m_rr = 0; m_lid = 0; m_fc = 0; m_acc = -1;
    m_lock = 1'b0; m_err = 1'b0; m_pa = '0;
    m_q.delete();
  endfunction

  function automatic int m_grant();
    if (m_lock && req_vld[m_lid]) return m_lid;
    for (int k = 0; k < N; k++)
      if (req_vld[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic m_check();
    int          g;
    bit          ev, pop;
    logic [N-1:0] er, es, ef;
    logic [31:0] eva;
    logic [27:0] epa;
    g   = m_grant();
    ev  = (g >= 0) && (m_q.size() < D);
    pop = wk_pa_vld && (m_q.size() > 0);
    er = '0; es = '0; ef = '0;
    if (ev && wk_rdy) er[g] = 1'b1;
    if (pop) begin
      es[m_q[0]] = 1'b1;
      ef[m_q[0]] = wk_fault;
    end
    eva = (g >= 0) ? req_va[32*g +: 32] : 32'h0;
    epa = pop ? wk_pa : m_pa;
    chk("rnd wk_va_vld", 32'(wk_va_vld), 32'(ev));
    chk("rnd wk_va", wk_va, eva);
    chk("rnd req_rdy", 32'(req_rdy), 32'(er));
    chk("rnd rsp_vld", 32'(rsp_vld), 32'(es));
    chk("rnd rsp_fault", 32'(rsp_fault), 32'(ef));
    chk("rnd rsp_pa", 32'(rsp_pa), 32'(epa));
    chk("rnd outstanding", 32'(outst), 32'(m_q.size()));
    chk("rnd fault_cnt", 32'(fcnt), 32'(m_fc));
    chk("rnd err", 32'(err), 32'(m_err));
  endtask

  function automatic void m_step();
    int g;
    bit ev, was_empty;
    g         = m_grant();
    ev        = (g >= 0) && (m_q.size() < D);
    was_empty = (m_q.size() == 0);
    m_acc     = -1;
    if (m_lock && !req_vld[m_lid]) begin
      m_err  = 1'b1;
      m_lock = 1'b0;
    end
    if (ev && !wk_rdy) begin
      m_lock = 1'b1;
      m_lid  = g;
    end
    if (wk_pa_vld) begin
      if (was_empty) m_err = 1'b1;
      else begin
        if (wk_fault && m_fc < 65535) m_fc++;
        void'(m_q.pop_front());
      end
      m_pa = wk_pa;
    end
    if (ev && wk_rdy) begin
      m_q.push_back(g);
      m_rr   = (g + 1) % N;
      m_lock = 1'b0;
      m_acc  = g;
    end
  endfunction

  task automatic tick(input bit use_model);
    #2;
    if (use_model) m_check();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] vld;
    logic       rdy, pav, flt;
    logic [3:0] e_rdy;
    logic       e_wv;
    logic [3:0] e_rsp, e_flt;
    int         e_out, e_fc;
    logic       e_err;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int onehot_idx;
    rst = 1'b1; req_va = '0; req_vld = '0; wk_rdy = 1'b0;
    wk_pa = '0; wk_pa_vld = 1'b0; wk_fault = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    #2;
    chk("reset outstanding", 32'(outst), 32'd0);
    chk("reset fault_cnt", 32'(fcnt), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rsp_pa", 32'(rsp_pa), 32'd0);
    chk("reset wk_va_vld", 32'(wk_va_vld), 32'd0);
    chk("reset rsp_vld", 32'(rsp_vld), 32'd0);
    tick(0);

    // Single requester round trip.
    req_vld = 4'b0001; req_va[31:0] = 32'h1234_5ABC; wk_rdy = 1'b1;
    #2;
    chk("single wk_va", wk_va, 32'h1234_5ABC);
    chk("single req_rdy", 32'(req_rdy), 32'h1);
    tick(0);
    req_vld = '0; wk_pa_vld = 1'b1; wk_pa = 28'h1234ABC;
    #2;
    chk("single outstanding", 32'(outst), 32'd1);
    chk("single rsp_vld", 32'(rsp_vld), 32'h1);
    chk("single rsp_pa", 32'(rsp_pa), 32'h1234ABC);
    tick(0);
    wk_pa_vld = 1'b0;
    #2;
    chk("single drained", 32'(outst), 32'd0);
    chk("single pa held", 32'(rsp_pa), 32'h1234ABC);
    tick(0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    //        vld      rdy   pav   flt   e_rdy    wv    e_rsp    e_flt  out fc err
    tbl[0]  = '{4'b1111,1'b1,1'b0,1'b0,4'b0001,1'b1,4'b0000,4'b0000,0,0,1'b0};
    tbl[1]  = '{4'b1111,1'b1,1'b0,1'b0,4'b0010,1'b1,4'b0000,4'b0000,1,0,1'b0};
    tbl[2]  = '{4'b1111,1'b1,1'b1,1'b0,4'b0100,1'b1,4'b0001,4'b0000,2,0,1'b0};
    tbl[3]  = '{4'b1111,1'b1,1'b1,1'b1,4'b1000,1'b1,4'b0010,4'b0010,2,0,1'b0};
    tbl[4]  = '{4'b1111,1'b1,1'b1,1'b0,4'b0001,1'b1,4'b0100,4'b0000,2,1,1'b0};
    tbl[5]  = '{4'b0000,1'b1,1'b1,1'b1,4'b0000,1'b0,4'b1000,4'b1000,2,1,1'b0};
    tbl[6]  = '{4'b0000,1'b1,1'b1,1'b0,4'b0000,1'b0,4'b0001,4'b0000,1,2,1'b0};
    tbl[7]  = '{4'b0100,1'b0,1'b0,1'b0,4'b0000,1'b1,4'b0000,4'b0000,0,2,1'b0};
    tbl[8]  = '{4'b0110,1'b0,1'b0,1'b0,4'b0000,1'b1,4'b0000,4'b0000,0,2,1'b0};
    tbl[9]  = '{4'b0110,1'b0,1'b0,1'b0,4'b0000,1'b1,4'b0000,4'b0000,0,2,1'b0};
    tbl[10] = '{4'b0110,1'b1,1'b0,1'b0,4'b0100,1'b1,4'b0000,4'b0000,0,2,1'b0};
    tbl[11] = '{4'b1010,1'b1,1'b0,1'b0,4'b1000,1'b1,4'b0000,4'b0000,1,2,1'b0};
    tbl[12] = '{4'b0010,1'b1,1'b0,1'b0,4'b0010,1'b1,4'b0000,4'b0000,2,2,1'b0};
    tbl[13] = '{4'b0001,1'b1,1'b0,1'b0,4'b0001,1'b1,4'b0000,4'b0000,3,2,1'b0};
    tbl[14] = '{4'b1111,1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,4'b0000,4,2,1'b0};
    tbl[15] = '{4'b1111,1'b1,1'b1,1'b0,4'b0000,1'b0,4'b0100,4'b0000,4,2,1'b0};
    tbl[16] = '{4'b1111,1'b1,1'b0,1'b0,4'b0010,1'b1,4'b0000,4'b0000,3,2,1'b0};
    tbl[17] = '{4'b0000,1'b1,1'b1,1'b1,4'b0000,1'b0,4'b1000,4'b1000,4,2,1'b0};
    tbl[18] = '{4'b0000,1'b1,1'b1,1'b0,4'b0000,1'b0,4'b0010,4'b0000,3,3,1'b0};
    tbl[19] = '{4'b0000,1'b1,1'b1,1'b0,4'b0000,1'b0,4'b0001,4'b0000,2,3,1'b0};
    tbl[20] = '{4'b0000,1'b1,1'b1,1'b0,4'b0000,1'b0,4'b0010,4'b0000,1,3,1'b0};
    tbl[21] = '{4'b0000,1'b1,1'b1,1'b0,4'b0000,1'b0,4'b0000,4'b0000,0,3,1'b0};
    tbl[22] = '{4'b0000,1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,4'b0000,0,3,1'b1};

    for (int i = 0; i < N; i++) req_va[32*i +: 32] = 32'hA000_0000 + 32'(i);

    for (int i = 0; i < 23; i++) begin
      req_vld   = tbl[i].vld;
      wk_rdy    = tbl[i].rdy;
      wk_pa_vld = tbl[i].pav;
      wk_fault  = tbl[i].flt;
      wk_pa     = 28'h0100000 + 28'(i);
      #2;
      chk($sformatf("t%0d req_rdy", i), 32'(req_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("t%0d wk_va_vld", i), 32'(wk_va_vld), 32'(tbl[i].e_wv));
      chk($sformatf("t%0d rsp_vld", i), 32'(rsp_vld), 32'(tbl[i].e_rsp));
      chk($sformatf("t%0d rsp_fault", i), 32'(rsp_fault), 32'(tbl[i].e_flt));
      chk($sformatf("t%0d outstanding", i), 32'(outst), 32'(tbl[i].e_out));
      chk($sformatf("t%0d fault_cnt", i), 32'(fcnt), 32'(tbl[i].e_fc));
      chk($sformatf("t%0d err", i), 32'(err), 32'(tbl[i].e_err));
      if (tbl[i].e_rsp != 4'b0000)
        chk($sformatf("t%0d rsp_pa", i), 32'(rsp_pa), 32'(wk_pa));
      if (tbl[i].e_rdy != 4'b0000) begin
        onehot_idx = 0;
        for (int k = 0; k < N; k++) if (tbl[i].e_rdy[k]) onehot_idx = k;
        chk($sformatf("t%0d wk_va", i), wk_va, 32'hA000_0000 + 32'(onehot_idx));
      end
      tick(0);
    end

    // Reset asserted with a request outstanding and valid inputs.
    req_vld = 4'b0001; wk_rdy = 1'b1; wk_pa_vld = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    chk("midrst outstanding", 32'(outst), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst fault_cnt", 32'(fcnt), 32'd0);
    chk("midrst wk_va_vld", 32'(wk_va_vld), 32'd0);
    chk("midrst req_rdy", 32'(req_rdy), 32'd0);
    chk("midrst rsp_pa", 32'(rsp_pa), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_vld = '0;
    m_reset();

    // Locked requester withdrawing its request.
    req_vld = 4'b0100; wk_rdy = 1'b0;
    tick(1);
    req_vld = 4'b0000;
    tick(1);
    #2;
    chk("drop err", 32'(err), 32'd1);
    tick(1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    req_vld = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && m_acc == i) begin
          if ($urandom_range(1, 0) == 0) req_vld[i] = 1'b0;
          req_va[32*i +: 32] = $urandom;
        end else if (!req_vld[i] && $urandom_range(9, 0) < 4) begin
          req_vld[i] = 1'b1;
          req_va[32*i +: 32] = $urandom;
        end
      end
      wk_rdy    = ($urandom_range(3, 0) != 0);
      wk_pa_vld = ($urandom_range(2, 0) == 0);
      wk_fault  = ($urandom_range(3, 0) == 0);
      wk_pa     = 28'($urandom);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
